// File: rtl/calc_core_p.sv
// calc_core_p: keypad calculator core. Builds two decimal operands, computes
// add/sub/mul/div (mul and div iterative) and streams results as BCD, LSD first.
module calc_core_p #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned WIDTH  = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                cmd,
  input  logic                      cmd_valid,
  output logic [1:0]                status,
  output logic [3:0]                data,
  output logic [$clog2(DIGITS)-1:0] pos,
  output logic                      data_valid,
  output logic                      neg,
  output logic [2:0]                state
);

  localparam int unsigned PosW = $clog2(DIGITS);
  localparam int unsigned NdW  = $clog2(DIGITS + 1);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [NdW-1:0]   NdMax   = NdW'(DIGITS);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntDig  = CntW'(DIGITS);
  localparam logic [WIDTH-1:0] Ten     = WIDTH'(10);

  localparam logic [1:0] StatReady = 2'b10;
  localparam logic [1:0] StatBusy  = 2'b01;
  localparam logic [1:0] StatErr   = 2'b00;

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpDiv = 2'd3;

  function automatic logic [2*WIDTH-1:0] max_val();
    logic [2*WIDTH-1:0] v;
    v = (2*WIDTH)'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      v = v * (2*WIDTH)'(10);
    end
    return v - (2*WIDTH)'(1);
  endfunction

  localparam logic [2*WIDTH-1:0] MaxVal = max_val();
  localparam logic [WIDTH:0]     MaxSum = MaxVal[WIDTH:0];

  typedef enum logic [2:0] {
    StEntryA = 3'd0,
    StOpWait = 3'd1,
    StEntryB = 3'd2,
    StCalc   = 3'd3,
    StPrint  = 3'd4,
    StError  = 3'd5,
    StResult = 3'd6
  } state_e;

  state_e             st_q, ret_q;
  logic [WIDTH-1:0]   acc_q, reg_a_q, reg_b_q, shadow_q;
  logic [1:0]         opr_q;
  logic [NdW-1:0]     ndig_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, rem_q, quo_q;

  // Key decode
  logic             key_ok, is_digit, is_op, is_eq, is_bs;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] cmd_ext;

  assign key_ok   = cmd_valid && (status == StatReady);
  assign is_digit = cmd < 4'd10;
  assign is_op    = (cmd >= 4'd10) && (cmd <= 4'd13);
  assign is_eq    = cmd == 4'd14;
  assign is_bs    = cmd == 4'd15;
  assign op_code  = 2'(cmd - 4'd10);
  assign cmd_ext  = {{(WIDTH-4){1'b0}}, cmd};

  // Operand editing for digit and backspace keys
  logic [WIDTH-1:0] edit_acc;
  logic [NdW-1:0]   edit_ndig;

  always_comb begin
    edit_acc  = acc_q;
    edit_ndig = ndig_q;
    if (st_q == StResult) begin
      edit_acc  = cmd_ext;
      edit_ndig = NdW'(1);
    end else if (is_bs) begin
      edit_acc  = acc_q / Ten;
      edit_ndig = (ndig_q == '0) ? '0 : ndig_q - 1'b1;
    end else if (ndig_q < NdMax) begin
      edit_acc  = (acc_q << 3) + (acc_q << 1) + cmd_ext;
      edit_ndig = ndig_q + 1'b1;
    end
  end

  // Arithmetic datapath
  logic [WIDTH:0]     sum;
  logic               a_lt_b;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic               last;

  assign sum       = {1'b0, reg_a_q} + {1'b0, reg_b_q};
  assign a_lt_b    = reg_a_q < reg_b_q;
  assign diff      = a_lt_b ? (reg_b_q - reg_a_q) : (reg_a_q - reg_b_q);
  assign prod_nxt  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, reg_b_q};
  // Remainder stays below the divisor, so WIDTH bits always hold it
  assign rem_nxt   = div_fits ? (div_shift[WIDTH-1:0] - reg_b_q) : div_shift[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], div_fits};
  assign last      = cnt_q == CntLast;

  logic             calc_done, calc_err, calc_neg;
  logic [WIDTH-1:0] calc_res;

  always_comb begin
    calc_done = 1'b0;
    calc_err  = 1'b0;
    calc_neg  = 1'b0;
    calc_res  = '0;
    unique case (opr_q)
      OpAdd: begin
        calc_done = 1'b1;
        calc_err  = sum > MaxSum;
        calc_res  = sum[WIDTH-1:0];
      end
      OpSub: begin
        calc_done = 1'b1;
        calc_neg  = a_lt_b;
        calc_res  = diff;
      end
      OpMul: begin
        calc_done = last;
        calc_err  = last && (prod_nxt > MaxVal);
        calc_res  = prod_nxt[WIDTH-1:0];
      end
      OpDiv: begin
        calc_done = last;
        calc_err  = (cnt_q == '0) && (reg_b_q == '0);
        calc_res  = quo_nxt;
      end
    endcase
  end

  assign state = st_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q       <= StEntryA;
      ret_q      <= StEntryA;
      acc_q      <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      opr_q      <= '0;
      ndig_q     <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      status     <= StatReady;
      data       <= '0;
      pos        <= '0;
      data_valid <= 1'b0;
      neg        <= 1'b0;
    end else begin
      unique case (st_q)
        StEntryA, StOpWait, StEntryB, StResult: begin
          if (key_ok) begin
            if (is_digit || (is_bs && st_q != StResult)) begin
              acc_q    <= edit_acc;
              ndig_q   <= edit_ndig;
              shadow_q <= edit_acc;
              cnt_q    <= '0;
              neg      <= 1'b0;
              ret_q    <= (st_q == StEntryA || st_q == StResult) ? StEntryA : StEntryB;
              st_q     <= StPrint;
              status   <= StatBusy;
            end else if (is_op) begin
              if (st_q == StOpWait) begin
                opr_q <= op_code;
              end else if (st_q == StEntryB || neg) begin
                st_q   <= StError;
                status <= StatErr;
              end else begin
                reg_a_q  <= acc_q;
                opr_q    <= op_code;
                acc_q    <= '0;
                ndig_q   <= '0;
                shadow_q <= '0;
                cnt_q    <= '0;
                ret_q    <= StOpWait;
                st_q     <= StPrint;
                status   <= StatBusy;
              end
            end else if (is_eq) begin
              if (st_q == StOpWait) begin
                st_q   <= StError;
                status <= StatErr;
              end else if (st_q == StEntryB) begin
                reg_b_q  <= acc_q;
                prod_q   <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, reg_a_q};
                mplier_q <= acc_q;
                rem_q    <= '0;
                quo_q    <= reg_a_q;
                cnt_q    <= '0;
                st_q     <= StCalc;
                status   <= StatBusy;
              end
            end
          end
        end
        StCalc: begin
          cnt_q    <= cnt_q + 1'b1;
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          rem_q    <= rem_nxt;
          quo_q    <= quo_nxt;
          if (calc_err) begin
            st_q   <= StError;
            status <= StatErr;
          end else if (calc_done) begin
            acc_q    <= calc_res;
            shadow_q <= calc_res;
            neg      <= calc_neg;
            cnt_q    <= '0;
            ret_q    <= StResult;
            st_q     <= StPrint;
          end
        end
        StPrint: begin
          if (cnt_q < CntDig) begin
            data       <= 4'(shadow_q % Ten);
            pos        <= PosW'(cnt_q);
            data_valid <= 1'b1;
            shadow_q   <= shadow_q / Ten;
            cnt_q      <= cnt_q + 1'b1;
          end else begin
            data_valid <= 1'b0;
            st_q       <= ret_q;
            status     <= StatReady;
          end
        end
        StError: begin
          status     <= StatErr;
          data_valid <= 1'b0;
        end
        default: begin
          st_q       <= StError;
          status     <= StatErr;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core_p.sv
// Self-checking bench for calc_core_p: scoreboard of expected BCD digits plus
// per-key status, latency and error checks.
module tb_calc_core_p;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 27;
  localparam int PW     = $clog2(DIGITS);

  localparam int KPrint   = 0;
  localparam int KIgnore  = 1;
  localparam int KDead    = 2;
  localparam int KErrNow  = 3;
  localparam int KErrCalc = 4;

  localparam logic [3:0] KAdd = 4'd10;
  localparam logic [3:0] KSub = 4'd11;
  localparam logic [3:0] KMul = 4'd12;
  localparam logic [3:0] KDiv = 4'd13;
  localparam logic [3:0] KEq  = 4'd14;
  localparam logic [3:0] KBs  = 4'd15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          data_valid;
  logic          neg;
  logic [2:0]    state;

  typedef struct packed {
    logic [3:0]    d;
    logic [PW-1:0] p;
    logic          n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  calc_core_p #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .data_valid (data_valid),
    .neg        (neg),
    .state      (state)
  );

  // Scoreboard consumer
  always @(negedge clock) begin
    if (data_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_digit: got data=%0d pos=%0d, required no output", data, pos);
      end else begin
        mon_e = sb.pop_front();
        if ({data, pos, neg} !== {mon_e.d, mon_e.p, mon_e.n}) begin
          errors++;
          $display("FAIL digit: got data=%0d pos=%0d neg=%b, required data=%0d pos=%0d neg=%b",
                   data, pos, neg, mon_e.d, mon_e.p, mon_e.n);
        end
      end
    end
  end

  task automatic push_print(input longint v, input bit ng);
    longint x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      exp_t ex;
      ex.d = 4'(x % 10);
      ex.p = PW'(i);
      ex.n = ng;
      sb.push_back(ex);
      x = x / 10;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic key(input logic [3:0] k, input int mode, input longint val = 0,
                     input bit ng = 1'b0, input int lat = 1);
    int  n;
    int  m;
    bit  ok;
    if (mode == KPrint) push_print(val, ng);
    @(negedge clock);
    cmd       = k;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    case (mode)
      KPrint: begin
        checks++;
        if (status !== 2'b01) begin
          errors++;
          $display("FAIL busy key=%0d: status=%b, required 01", k, status);
        end
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (data_valid !== 1'b1 && n < 200);
        checks++;
        if (n !== lat) begin
          errors++;
          $display("FAIL latency key=%0d: first data_valid after %0d edges, required %0d",
                   k, n, lat);
        end
        m = n;
        while (status !== 2'b10 && m < n + 200) begin
          @(negedge clock);
          m++;
        end
        checks++;
        if (m !== lat + DIGITS || data_valid !== 1'b0) begin
          errors++;
          $display("FAIL ready key=%0d: ready after %0d edges dv=%b, required %0d dv=0",
                   k, m, data_valid, lat + DIGITS);
        end
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL print_count key=%0d: %0d digits missing, required 0", k, sb.size());
        end
      end
      KIgnore, KDead: begin
        ok = 1'b1;
        repeat (4) begin
          if (status !== ((mode == KIgnore) ? 2'b10 : 2'b00) || data_valid !== 1'b0) ok = 1'b0;
          @(negedge clock);
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL ignored key=%0d: status=%b dv=%b, required %b dv=0", k, status,
                   data_valid, (mode == KIgnore) ? 2'b10 : 2'b00);
        end
      end
      KErrNow: begin
        checks++;
        if (status !== 2'b00 || data_valid !== 1'b0) begin
          errors++;
          $display("FAIL error key=%0d: status=%b dv=%b, required 00 dv=0", k, status, data_valid);
        end
      end
      default: begin
        checks++;
        if (status !== 2'b01) begin
          errors++;
          $display("FAIL calc_busy key=%0d: status=%b, required 01", k, status);
        end
        @(negedge clock);
        checks++;
        if (status !== 2'b00 || data_valid !== 1'b0) begin
          errors++;
          $display("FAIL calc_error key=%0d: status=%b dv=%b, required 00 dv=0", k, status,
                   data_valid);
        end
      end
    endcase
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (status !== 2'b10) begin errors++; $display("FAIL rst_status: %b vs 10", status); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: %b vs 0", data_valid); end
    checks++;
    if (data !== 4'd0 || pos !== '0) begin
      errors++;
      $display("FAIL rst_data: data=%0d pos=%0d vs 0 0", data, pos);
    end
    checks++;
    if (neg !== 1'b0) begin errors++; $display("FAIL rst_neg: %b vs 0", neg); end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rst_state: %0d vs 0", state); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    key(KEq, KIgnore);
    key(4'd1, KPrint, 1);
    key(4'd2, KPrint, 12);
    key(KAdd, KPrint, 0);
    key(4'd3, KPrint, 3);
    key(4'd4, KPrint, 34);
    key(KEq, KPrint, 12 + 34, 1'b0, 2);
  endtask

  task automatic test_sub();
    do_reset();
    key(4'd5, KPrint, 5);
    key(KSub, KPrint, 0);
    key(4'd9, KPrint, 9);
    key(KEq, KPrint, 4, 1'b1, 2);
    key(4'd6, KPrint, 6, 1'b0);
    key(KSub, KPrint, 0);
    key(4'd2, KPrint, 2);
    key(KEq, KPrint, 6 - 2, 1'b0, 2);
    do_reset();
    key(4'd5, KPrint, 5);
    key(KSub, KPrint, 0);
    key(4'd9, KPrint, 9);
    key(KEq, KPrint, 4, 1'b1, 2);
    key(KAdd, KErrNow);
  endtask

  task automatic test_mul_chain();
    do_reset();
    key(4'd1, KPrint, 1);
    key(4'd2, KPrint, 12);
    key(4'd3, KPrint, 123);
    key(KMul, KPrint, 0);
    key(4'd4, KPrint, 4);
    key(4'd5, KPrint, 45);
    key(KEq, KPrint, 123 * 45, 1'b0, WIDTH + 1);
    key(KBs, KIgnore);
    key(KEq, KIgnore);
    key(KAdd, KPrint, 0);
    key(4'd5, KPrint, 5);
    key(KEq, KPrint, 123 * 45 + 5, 1'b0, 2);
  endtask

  task automatic test_div();
    do_reset();
    key(4'd1, KPrint, 1);
    key(4'd0, KPrint, 10);
    key(4'd0, KPrint, 100);
    key(KMul, KPrint, 0);
    key(KSub, KIgnore);
    key(KDiv, KIgnore);
    key(4'd7, KPrint, 7);
    key(KEq, KPrint, 100 / 7, 1'b0, WIDTH + 1);
    do_reset();
    key(4'd7, KPrint, 7);
    key(KDiv, KPrint, 0);
    key(4'd0, KPrint, 0);
    key(KEq, KErrCalc);
    key(4'd3, KDead);
  endtask

  task automatic test_errors();
    do_reset();
    key(4'd2, KPrint, 2);
    key(KMul, KPrint, 0);
    key(KEq, KErrNow);
    do_reset();
    key(4'd2, KPrint, 2);
    key(KMul, KPrint, 0);
    key(4'd3, KPrint, 3);
    key(KAdd, KErrNow);
  endtask

  task automatic test_overflow();
    longint v;
    do_reset();
    v = 0;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (i < DIGITS) v = v * 10 + 9;
      key(4'd9, KPrint, v);
    end
    key(KAdd, KPrint, 0);
    key(4'd1, KPrint, 1);
    key(KEq, KErrCalc);
  endtask

  task automatic test_backspace_reset();
    bit ok;
    do_reset();
    key(KBs, KPrint, 0);
    key(4'd4, KPrint, 4);
    key(4'd2, KPrint, 42);
    key(KBs, KPrint, 4);
    key(4'd8, KPrint, 48);
    key(KMul, KPrint, 0);
    key(4'd9, KPrint, 9);
    @(negedge clock);
    cmd       = KEq;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (status !== 2'b10 || data_valid !== 1'b0 || state !== 3'd0 || neg !== 1'b0 ||
        data !== 4'd0 || pos !== '0) begin
      errors++;
      $display("FAIL mid_calc_reset: status=%b dv=%b state=%0d neg=%b data=%0d pos=%0d",
               status, data_valid, state, neg, data, pos);
    end
    @(negedge clock);
    reset = 1'b0;
    ok = 1'b1;
    repeat (WIDTH + 10) begin
      if (data_valid !== 1'b0 || status !== 2'b10) ok = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_quiet: dv=%b status=%b, required dv=0 status=10",
               data_valid, status);
    end
    key(4'd3, KPrint, 3);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_chain();
    test_div();
    test_errors();
    test_overflow();
    test_backspace_reset();
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
